// File: rtl/fft16_pkg.sv
// Shared constants and state type for the 16-point FFT front end.
package fft16_pkg;
  localparam int N_POINTS      = 16;
  localparam int QUAD_LANES    = 4;
  localparam int CNT_W         = 4;
  localparam int SEL_W         = 2;
  localparam int WORD_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/fft16_quad_loader.sv
// Single-buffer frame loader: collects 16 serial samples, then replays them as
// radix-4 quads (x[q], x[q+4], x[q+8], x[q+12]) with a rotating mux select.
module fft16_quad_loader
  import fft16_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_SIZE-1:0] out_a,
  output logic [WORD_SIZE-1:0] out_b,
  output logic [WORD_SIZE-1:0] out_c,
  output logic [WORD_SIZE-1:0] out_d,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [WORD_SIZE-1:0] mem_q [N_POINTS];
  logic                 wr_en;

  logic                 drain;
  logic [SEL_W-1:0]     quad;
  logic [WORD_SIZE-1:0] lane [QUAD_LANES];

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    beat_d   = beat_q;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == CNT_W'(N_POINTS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == CNT_W'(N_POINTS - 1)) state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      beat_q   <= beat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POINTS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_cnt_q] <= in_data;
    end
  end

  // All outputs decode from registered state; nothing combinational from the handshake inputs.
  assign drain = (state_q == DRAIN);
  assign quad  = beat_q[CNT_W-1:SEL_W];

  for (genvar j = 0; j < QUAD_LANES; j++) begin : g_lane
    assign lane[j] = drain ? mem_q[{SEL_W'(j), quad}] : '0;
  end

  assign out_a     = lane[0];
  assign out_b     = lane[1];
  assign out_c     = lane[2];
  assign out_d     = lane[3];
  assign out_sel   = drain ? beat_q[SEL_W-1:0] : '0;
  assign out_valid = drain;
  assign out_last  = drain && (beat_q == CNT_W'(N_POINTS - 1));
  assign in_ready  = (state_q == FILL);

endmodule
